// File: rtl/logic_l6_if.sv
// Consumer-side handshake of the logic_l6 change-capture FIFO.
// The FIFO drives the head entry and valid. The consumer drives ready.
interface logic_l6_if #(
  parameter int PAR_DATA_BITS = 8
) ();
  // Transfer rule: the head is consumed at the edge where ob_valid && ib_ready.
  // The head stays stable while ob_valid && !ib_ready.
  // ib_ready is ignored while ob_valid is low.
  logic [PAR_DATA_BITS-1:0] ovG_data;
  logic                     ob_valid;
  logic                     ib_ready;

  modport master (output ovG_data, output ob_valid, input ib_ready);
  modport slave  (input ovG_data, input ob_valid, output ib_ready);
endinterface

// File: rtl/logic_l6.sv
// Change-capture stage: pushes every new accumulator value into a show-ahead FIFO.
// Optional saturating drop counter enabled by LOGIC_L6_DROP_CNT_EN.
module logic_l6 #(
  parameter int PAR_DATA_BITS  = 8,
  parameter int PAR_DEPTH      = 4,
  parameter int PAR_DEPTH_BITS = 2,
  parameter int PAR_DROP_BITS  = 8
) (
  input  logic                      ib_clk,
  input  logic                      ib_rst,
  input  logic [PAR_DATA_BITS-1:0]  ivG_data,
  logic_l6_if.master                bus,
  output logic [PAR_DEPTH_BITS:0]   ovG_level,
  output logic                      ob_full,
  output logic [PAR_DROP_BITS-1:0]  ovG_drop_cnt
);

  logic [PAR_DATA_BITS-1:0]  mem [PAR_DEPTH];
  logic [PAR_DATA_BITS-1:0]  rvG_prev;
  logic [PAR_DEPTH_BITS-1:0] wr_ptr;
  logic [PAR_DEPTH_BITS-1:0] rd_ptr;
  logic [PAR_DEPTH_BITS:0]   level;
  logic                      change;
  logic                      pop;
  logic                      push;

  // Outputs depend only on registered state, never on ib_ready or ivG_data.
  assign ovG_level    = level;
  assign ob_full      = (level == (PAR_DEPTH_BITS+1)'(PAR_DEPTH));
  assign bus.ob_valid = (level != '0);
  assign bus.ovG_data = bus.ob_valid ? mem[rd_ptr] : '0;

  assign change = (ivG_data != rvG_prev);
  assign pop    = bus.ob_valid & bus.ib_ready;
  // When full, a pop in the same cycle frees the slot for the new value.
  assign push   = change & (~ob_full | pop);

  always_ff @(posedge ib_clk) begin
    if (ib_rst) begin
      rvG_prev <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      rvG_prev <= ivG_data;
      if (push) wr_ptr <= wr_ptr + PAR_DEPTH_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PAR_DEPTH_BITS'(1);
      if (push && !pop)      level <= level + (PAR_DEPTH_BITS+1)'(1);
      else if (pop && !push) level <= level - (PAR_DEPTH_BITS+1)'(1);
    end
  end

  // Storage needs no reset: entries are invalidated by the pointer and level reset.
  always_ff @(posedge ib_clk) begin
    if (push) mem[wr_ptr] <= ivG_data;
  end

`ifdef LOGIC_L6_DROP_CNT_EN
  logic                     drop;
  logic [PAR_DROP_BITS-1:0] drop_cnt;

  assign drop         = change & ob_full & ~pop;
  assign ovG_drop_cnt = drop_cnt;

  always_ff @(posedge ib_clk) begin
    if (ib_rst)                     drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + PAR_DROP_BITS'(1);
  end
`else
  assign ovG_drop_cnt = '0;
`endif

endmodule

// File: doc/logic_l6.md
# logic_l6

Downstream change-capture stage for the XOR accumulator stage. It samples the accumulator output every cycle and detects when the value changes. Each new value is pushed into a small show-ahead FIFO, and the FIFO is drained by a consumer over a valid/ready handshake. It isolates the free-running accumulator from a consumer that can stall, and counts changes lost to overflow.

## Interface
- PAR_DATA_BITS, 8, width of captured data; equals accumulator width
- PAR_DEPTH, 4, FIFO entries; power of two, ≥2
- PAR_DEPTH_BITS, 2, log2(PAR_DEPTH)
- PAR_DROP_BITS, 8, drop counter width
- ib_clk  input  1  clock; all logic on rising edge
- ib_rst  input  1  reset, synchronous, active-high
- ivG_data  input  PAR_DATA_BITS  accumulator value from the upstream stage's ovG_data
- ovG_data  output  PAR_DATA_BITS  FIFO head; 0 when empty
- ob_valid  output  1  FIFO non-empty
- ib_ready  input  1  consumer accepts head this cycle
- ovG_level  output  PAR_DEPTH_BITS+1  entries held, 0..PAR_DEPTH
- ob_full  output  1  level == PAR_DEPTH
- ovG_drop_cnt  output  PAR_DROP_BITS  saturating count of dropped changes

## Operation
- rvG_prev register: loads ivG_data every cycle; reset value 0. This matches the upstream reset value, so there is no spurious capture after reset.
- change = (ivG_data != rvG_prev), combinational.
- pop = ob_valid & ib_ready.
- push_req = change.
- push = push_req & (!ob_full | pop). When the FIFO is full, a simultaneous pop frees the slot, so the push is accepted.
- drop = push_req & ob_full & !pop.
- Write pointer and read pointer are each PAR_DEPTH_BITS wide and wrap modulo PAR_DEPTH. Level is held in a separate counter:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- Pop when empty is impossible because ob_valid=0. ib_ready is ignored when empty.
- Entries are written in change order and read in FIFO order; no reordering, no merging.
- ovG_data = mem[rd_ptr] when level≠0, else 0.
- Drop counter: increments on drop and saturates at all-ones. It never wraps.
- Reset mid-operation: on the next edge, the following are cleared:
  - pointers, level, rvG_prev, drop counter
  - stored entries, which are discarded; memory contents need no reset
- Reset values:
  - ovG_data=0, ob_valid=0, ovG_level=0, ob_full=0, ovG_drop_cnt=0.

## Timing
- Capture latency:
  - ivG_data changes to a new value V before edge k.
  - V is written at edge k.
  - If the FIFO was empty, ob_valid=1 and ovG_data=V after edge k (1 cycle).
- Handshake:
  - Head is consumed at the edge where ob_valid & ib_ready.
  - The next entry, or 0 and ob_valid=0, appears after that edge.
  - Sustained throughput is one entry per cycle.
- ob_valid, ovG_data, ovG_level and ob_full are registered-state-derived only. They have no combinational path from ib_ready or ivG_data.
- ovG_drop_cnt updates one edge after the dropped change.

## Configuration
- LOGIC_L6_DROP_CNT_EN defined:
  - the drop counter is implemented as above.
- LOGIC_L6_DROP_CNT_EN undefined:
  - no counter register.
  - ovG_drop_cnt is tied to 0.
  - Dropped changes are silently discarded.
  - All other behaviour is identical.

## Test plan
- Reset, ivG_data held at 0 for 10 cycles:
  - ob_valid=0, ovG_data=0, ovG_level=0 throughout.
- ib_ready=1; ivG_data goes 0→0x5A at edge 3, held, then 0x5A→0x3C at edge 6:
  - exactly two transfers, 0x5A then 0x3C.
  - each appears 1 cycle after its capture edge.
  - no repeats while the value is held.
- ib_ready=0; ivG_data changes every cycle through 0x01,0x02,0x03,0x04,0x05,0x06:
  - level reaches 4 and ob_full=1.
  - 0x05 and 0x06 are dropped; ovG_drop_cnt=2 (macro on) or 0 (macro off).
  - Then ib_ready=1: outputs are 0x01..0x04 in order, and ob_valid drops after the 4th.
- Full FIFO, ib_ready=1, and a new value 0x77 in the same cycle:
  - push accepted, level stays 4, no drop.
  - 0x77 is read out last.
- PAR_DROP_BITS=2, 5 drops while full:
  - ovG_drop_cnt sticks at 3.
- FIFO holding 3 entries; ib_rst asserted for one cycle mid-stream:
  - after the edge: level=0, ob_valid=0, ovG_drop_cnt=0.
  - the first change after reset is captured normally.
